// File: rtl/kbd_hotkey_ctrl.sv
// Keyboard hotkey controller: F5 reset, F7 PAL/NTSC, F8 scandoubler override,
// Enter tracking, optional F9 ROM select (ROMSEL_HOTKEY_EN), reset countdown and config capture.
module kbd_hotkey_ctrl #(
  parameter logic [7:0] RESET_CYCLES  = 8'd255,
  parameter logic [7:0] CFG_SAMPLE_AT = 8'd3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       kb_interrupt,
  input  logic [7:0] scancode,
  input  logic       released,
  input  logic       extended,
  input  logic [7:0] sram_data,
  output logic       pal,
  output logic       sd_override,
  output logic [1:0] rom_version,
  output logic       enter_key,
  output logic       core_reset_n,
  output logic       cfg_addr_sel,
  output logic [7:0] scandblr_reg,
  output logic       scandoubler_en
);

  localparam logic [7:0] KEY_F5    = 8'h03;
  localparam logic [7:0] KEY_F7    = 8'h83;
  localparam logic [7:0] KEY_F8    = 8'h0A;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  // [0],[1] synchronise the strobe; [2] holds the previous value for edge detect
  logic [2:0] kb_sync;
  logic       key_evt;
  logic       kbd_reset;
  logic       kbd_rom;
  logic [7:0] countdown;
  logic       first_read;

  assign key_evt = kb_sync[1] & ~kb_sync[2] & ~extended;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) kb_sync <= 3'b000;
    else          kb_sync <= {kb_sync[1:0], kb_interrupt};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pal         <= 1'b1;
      sd_override <= 1'b0;
      enter_key   <= 1'b0;
      kbd_reset   <= 1'b0;
    end else if (key_evt) begin
      case (scancode)
        KEY_F5:    kbd_reset <= ~released;
        KEY_F7:    if (!released) pal <= ~pal;
        KEY_F8:    if (!released) sd_override <= ~sd_override;
        KEY_ENTER: enter_key <= ~released;
        default:   ;
      endcase
    end
  end

`ifdef ROMSEL_HOTKEY_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      kbd_rom     <= 1'b0;
      rom_version <= 2'd0;
    end else if (key_evt && scancode == 8'h01) begin
      kbd_rom <= ~released;
      if (!released) rom_version <= (rom_version == 2'd2) ? 2'd0 : rom_version + 2'd1;
    end
  end
`else
  assign kbd_rom     = 1'b0;
  assign rom_version = 2'd0;
`endif

  // Config byte is captured only on the power-on countdown; hotkey resets keep it
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      countdown    <= RESET_CYCLES;
      core_reset_n <= 1'b0;
      scandblr_reg <= 8'h00;
      first_read   <= 1'b1;
    end else begin
      if (kbd_reset || kbd_rom)  countdown <= RESET_CYCLES;
      else if (countdown != 8'd0) countdown <= countdown - 8'd1;
      core_reset_n <= (countdown == 8'd0);
      if (countdown == CFG_SAMPLE_AT && first_read) begin
        scandblr_reg <= sram_data;
        first_read   <= 1'b0;
      end
    end
  end

  assign cfg_addr_sel   = ~core_reset_n;
  assign scandoubler_en = ~scandblr_reg[0] ^ sd_override;

endmodule

// File: tb/tb_kbd_hotkey_ctrl.sv
// Directed bench for kbd_hotkey_ctrl: expected values queued at stimulus, checked on sampling.
module tb_kbd_hotkey_ctrl;
  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       kb_interrupt = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       released = 1'b0;
  logic       extended = 1'b0;
  logic [7:0] sram_data = 8'h01;
  logic       pal, sd_override, enter_key, core_reset_n, cfg_addr_sel, scandoubler_en;
  logic [1:0] rom_version;
  logic [7:0] scandblr_reg;

  kbd_hotkey_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kb_interrupt(kb_interrupt),
    .scancode(scancode), .released(released), .extended(extended),
    .sram_data(sram_data), .pal(pal), .sd_override(sd_override),
    .rom_version(rom_version), .enter_key(enter_key), .core_reset_n(core_reset_n),
    .cfg_addr_sel(cfg_addr_sel), .scandblr_reg(scandblr_reg),
    .scandoubler_en(scandoubler_en)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { string tag; logic [7:0] exp; } sb_t;
  sb_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Event is applied on the 3rd edge after the strobe rises; task returns 4 edges later
  task automatic key(input logic [7:0] code, input logic rel, input logic ext);
    scancode = code; released = rel; extended = ext;
    kb_interrupt = 1'b1;
    step(4);
    kb_interrupt = 1'b0;
    step(3);
  endtask

  initial begin
    step(2);
    push("rst_pal", 8'h1);          chk(pal);
    push("rst_sd_override", 8'h0);  chk(sd_override);
    push("rst_rom_version", 8'h0);  chk(rom_version);
    push("rst_enter_key", 8'h0);    chk(enter_key);
    push("rst_core_reset_n", 8'h0); chk(core_reset_n);
    push("rst_cfg_addr_sel", 8'h1); chk(cfg_addr_sel);
    push("rst_scandblr_reg", 8'h0); chk(scandblr_reg);

    // power-on countdown: capture on edge 253, core_reset_n rises on edge 256
    reset_n = 1'b1;
    push("pwr_no_capture_yet", 8'h00); step(252); chk(scandblr_reg);
    push("pwr_capture", 8'h01);        step(1);   chk(scandblr_reg);
    push("pwr_core_still_low", 8'h0);  step(2);   chk(core_reset_n);
    push("pwr_core_release", 8'h1);    step(1);   chk(core_reset_n);
    push("pwr_cfg_addr_sel", 8'h0);    chk(cfg_addr_sel);
    push("pwr_scandoubler_en", 8'h0);  chk(scandoubler_en);
    sram_data = 8'hFF;

    // F7 make/break/make
    push("f7_make1", 8'h0);  key(8'h83, 1'b0, 1'b0); chk(pal);
    push("f7_break", 8'h0);  key(8'h83, 1'b1, 1'b0); chk(pal);
    push("f7_make2", 8'h1);  key(8'h83, 1'b0, 1'b0); chk(pal);

    // F8 toggles the override and thus the scandoubler enable
    push("f8_make", 8'h1);   key(8'h0A, 1'b0, 1'b0); chk(sd_override);
    push("f8_sd_en", 8'h1);  chk(scandoubler_en);
    push("f8_break", 8'h1);  key(8'h0A, 1'b1, 1'b0); chk(sd_override);

    // extended-prefix filter on Enter
    push("enter_ext", 8'h0);   key(8'h5A, 1'b0, 1'b1); chk(enter_key);
    push("enter_make", 8'h1);  key(8'h5A, 1'b0, 1'b0); chk(enter_key);
    push("enter_break", 8'h0); key(8'h5A, 1'b1, 1'b0); chk(enter_key);

    // unrelated code: no change
    push("other_pal", 8'h1);  key(8'h1C, 1'b0, 1'b0); chk(pal);
    push("other_core", 8'h1); chk(core_reset_n);

`ifdef ROMSEL_HOTKEY_EN
    push("f9_rom1", 8'h1); key(8'h01, 1'b0, 1'b0); chk(rom_version);
    push("f9_core_low", 8'h0); chk(core_reset_n);
    key(8'h01, 1'b1, 1'b0);
    push("f9_rom2", 8'h2); key(8'h01, 1'b0, 1'b0); chk(rom_version);
    key(8'h01, 1'b1, 1'b0);
    push("f9_rom0", 8'h0); key(8'h01, 1'b0, 1'b0); chk(rom_version);
    push("f9_hold_low", 8'h0); step(300); chk(core_reset_n);
    key(8'h01, 1'b1, 1'b0);
    push("f9_core_low_255", 8'h0); step(251); chk(core_reset_n);
    push("f9_core_high_256", 8'h1); step(1); chk(core_reset_n);
    push("f9_no_recapture", 8'h01); chk(scandblr_reg);
`else
    push("nof9_rom", 8'h0);  key(8'h01, 1'b0, 1'b0); chk(rom_version);
    push("nof9_core", 8'h1); step(5); chk(core_reset_n);
    key(8'h01, 1'b1, 1'b0);
`endif

    // F5: start a countdown, then press again mid-countdown
    push("f5_core_low", 8'h0); key(8'h03, 1'b0, 1'b0); chk(core_reset_n);
    key(8'h03, 1'b1, 1'b0);
    step(148);
    key(8'h03, 1'b0, 1'b0);
    push("f5_reload_hold", 8'h0); step(200); chk(core_reset_n);
    key(8'h03, 1'b1, 1'b0);
    push("f5_core_low_255", 8'h0); step(251); chk(core_reset_n);
    push("f5_core_high_256", 8'h1); step(1); chk(core_reset_n);
    push("f5_no_recapture", 8'h01); chk(scandblr_reg);

    if (sb_q.size() != 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbd_hotkey_ctrl.md
KBD_HOTKEY_CTRL -- requirements
Module: kbd_hotkey_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 255: power-on/hotkey reset countdown length in clk_sys cycles, 8-bit.
REQ-002 SHALL have parameter CFG_SAMPLE_AT, default 3: countdown value at which the SRAM config byte is captured.
REQ-003 SHALL have port clk_sys, input, 1 bit: system clock; all state on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port kb_interrupt, input, 1 bit: PS/2 decoder strobe, one new code per rising edge.
REQ-006 SHALL have port scancode, input, 8 bits: PS/2 scancode, valid while kb_interrupt is high.
REQ-007 SHALL have ports released and extended, input, 1 bit each: break flag and E0-prefix flag.
REQ-008 SHALL have port sram_data, input, 8 bits: SRAM read data while cfg_addr_sel is high.
REQ-009 SHALL have port pal, output, 1 bit: 1 = PAL, 0 = NTSC.
REQ-010 SHALL have port sd_override, output, 1 bit: scandoubler override toggle.
REQ-011 SHALL have port rom_version, output, 2 bits: selected ROM, 0 to 2.
REQ-012 SHALL have port enter_key, output, 1 bit: Enter key held.
REQ-013 SHALL have port core_reset_n, output, 1 bit: active-low reset to core and SRAM arbiter.
REQ-014 SHALL have port cfg_addr_sel, output, 1 bit: high forces the SRAM address to the config location and WE low.
REQ-015 SHALL have port scandblr_reg, output, 8 bits: captured video config byte.
REQ-016 SHALL have port scandoubler_en, output, 1 bit: combinational ~scandblr_reg[0] XOR sd_override.

Function
REQ-017 SHALL synchronise kb_interrupt through 2 flops and detect its rising edge; a key event is valid exactly 1 cycle per edge.
REQ-018 SHALL sample scancode, released and extended on the key-event cycle; events with extended=1 SHALL be ignored.
REQ-019 SHALL treat code 0x03 (F5) as reset request: kbd_reset = ~released.
REQ-020 SHALL toggle pal on code 0x83 (F7) make only; break events do nothing.
REQ-021 SHALL toggle sd_override on code 0x0A (F8) make only.
REQ-022 SHALL treat code 0x01 (F9) as ROM change: kbd_rom = ~released; on make, rom_version advances 0->1->2->0.
REQ-023 SHALL drive enter_key = ~released on code 0x5A.
REQ-024 SHALL ignore all other codes with no output change.
REQ-025 SHALL keep an 8-bit countdown: reload to RESET_CYCLES while kbd_reset or kbd_rom is high, else decrement until 0, then hold.
REQ-026 SHALL register core_reset_n = (countdown == 0), so it is 1 cycle behind the counter.
REQ-027 SHALL drive cfg_addr_sel = ~core_reset_n.
REQ-028 SHALL load scandblr_reg from sram_data on the cycle countdown == CFG_SAMPLE_AT, only if first_read = 1, and SHALL then clear first_read.
REQ-029 SHALL keep first_read cleared across hotkey resets, so later countdowns do not recapture.
REQ-030 SHALL restart the countdown from RESET_CYCLES when a hotkey reset arrives mid-countdown; core_reset_n stays low.
REQ-031 SHALL apply a toggle event and a capture or counter update in the same cycle independently.

Reset
REQ-032 SHALL, on reset_n low, asynchronously set: pal=1, sd_override=0, rom_version=0, enter_key=0, kbd_reset=0, kbd_rom=0, countdown=RESET_CYCLES, core_reset_n=0, scandblr_reg=0x00, first_read=1, synchroniser flops=0.
REQ-033 SHALL start counting down on the first clk_sys edge after reset_n deasserts.

Configuration
REQ-034 SHALL implement the F9 ROM-change hotkey only when macro ROMSEL_HOTKEY_EN is defined.
REQ-035 SHALL, without ROMSEL_HOTKEY_EN, ignore code 0x01, hold rom_version at 0 and kbd_rom at 0.

Verification
REQ-036 SHALL cover power-on: reset_n released, sram_data=0x01 -> scandblr_reg=0x01 at count 3, core_reset_n rises 256 cycles after release, scandoubler_en=0.
REQ-037 SHALL cover F7: make 0x83 -> pal 1->0; break 0x83 -> pal stays 0; second make -> pal=1.
REQ-038 SHALL cover F9: three make/break pairs -> rom_version 1,2,0; core_reset_n low while held plus 256 cycles; scandblr_reg unchanged despite sram_data=0xFF.
REQ-039 SHALL cover F5 mid-countdown: make at count 100 -> countdown reloads to 255 while held; after break, 256 more cycles before core_reset_n=1.
REQ-040 SHALL cover extended filter: extended=1 with code 0x5A -> enter_key stays 0; extended=0 make -> 1; break -> 0.
REQ-041 SHALL cover the build without ROMSEL_HOTKEY_EN: make 0x01 -> rom_version=0 and core_reset_n stays 1.
